alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Shares one ALU datapath between two requesters (e.g. main pipeline and a helper unit).
- Arbitrates, latches the winner's operands and control code, executes for one cycle, then returns a registered result with zero flag and requester ID.
- Uses valid/ready handshakes on both request ports and the response port; the response is held under backpressure.

Parameters:
- DATA_W, 32, operand/result width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority (req0 wins).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_src1_i  input  DATA_W  requester 0 operand 1.
- req0_src2_i  input  DATA_W  requester 0 operand 2.
- req0_ctrl_i  input  4  requester 0 ALU control code.
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i  same as req0, for requester 1.
- rsp_valid_o  output  1  result available.
- rsp_ready_i  input  1  consumer takes the result.
- rsp_id_o  output  1  requester that owns the result.
- rsp_result_o  output  DATA_W  ALU result.
- rsp_zero_o  output  1  result == 0.
- rsp_illegal_o  output  1  control code was unsupported.

Behaviour:
- States: IDLE, EXEC, RESP. Reset values:
  - state = IDLE; all rsp_* outputs 0; operand/ctrl registers 0.
  - last_grant = 1, so req0 wins the first contention.
- Accept window: state == IDLE, or (state == RESP and rsp_ready_i == 1) for back-to-back operation.
- Arbitration inside the accept window:
  - One valid: that requester is granted.
  - Both valid, RR_EN = 1: the requester that was not last granted wins.
  - Both valid, RR_EN = 0: req0 wins.
- Grant side effects:
  - reqN_ready_o = 1 combinationally for the granted requester only; never both.
  - On the edge: latch src1/src2/ctrl/id, update last_grant, go to EXEC.
- No request in the accept window:
  - IDLE stays IDLE.
  - RESP with rsp_ready_i goes to IDLE, rsp_valid_o drops.
- EXEC, one cycle, ALU on the latched operands, registered into rsp_*:
  - 0: AND
  - 1: OR
  - 2: ADD, modulo 2^DATA_W, no carry out
  - 6: SUB, modulo 2^DATA_W
  - 7: SLT, unsigned compare, result 1 or 0
  - 12: NOR
  - Any other code: result 0, rsp_illegal_o = 1.
  - rsp_zero_o = (result == 0), including illegal codes.
  - Always moves to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_* stable until the cycle rsp_ready_i = 1.
  - Without rsp_ready_i: stay in RESP, no new accept.
- Latency: accept at edge N gives rsp_valid_o high after edge N+1. Max throughput is one op per 2 cycles with rsp_ready_i held high.
- Request inputs are sampled only in the grant cycle; changes afterwards do not affect the in-flight op.
- Ungranted requesters keep valid asserted; no drop rule is enforced.
- Reset mid-operation: immediately returns to IDLE and clears rsp_valid_o. The in-flight op is discarded, not replayed.

Decomposition:
- Package alu_share_pkg:
  - ALU control code constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12.
  - State encoding typedef (IDLE/EXEC/RESP).
  - Requester ID width constant.
- Sub-module: the existing ALU block (src1/src2/ctrl -> result/zero), instantiated combinationally on the latched operands.
  - The legal-code decode that drives rsp_illegal_o stays in this controller.

Test Plan:
- Single op: req0 ADD 0x7FFFFFFF+1 -> req0_ready_o 1 for one cycle; one cycle later rsp_valid_o=1, result 0x80000000, zero 0, id 0.
- Contention (RR_EN=1): both valid each cycle, rsp_ready_i=1 -> grants alternate 0,1,0,1; rsp_id_o follows 0,1,0,1; one result every 2 cycles.
- Backpressure: req1 SUB 5-5, rsp_ready_i low for 4 cycles -> result 0, zero 1, id 1 stable; req ready_o stays 0 during hold.
- Opcodes: SLT 0xFFFFFFFF<1 -> 0; NOR 0,0 -> 0xFFFFFFFF; ctrl 3 -> result 0, zero 1, illegal 1.
- Fixed priority (RR_EN=0): both valid for 3 ops -> all granted to req0.
- Reset: assert rst_i low during EXEC -> rsp_valid_o 0 at once, state IDLE; after release, req1 op completes normally.

Source files
------------

// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// alu_share_pkg : control codes, state encoding and ID width for alu_share_ctrl
// Revision: 1.0
// ============================================================================
package alu_share_pkg;

  localparam int unsigned C_ID_W = 1;

  localparam logic [3:0] c_alu_and = 4'd0;
  localparam logic [3:0] c_alu_or  = 4'd1;
  localparam logic [3:0] c_alu_add = 4'd2;
  localparam logic [3:0] c_alu_sub = 4'd6;
  localparam logic [3:0] c_alu_slt = 4'd7;
  localparam logic [3:0] c_alu_nor = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      c_alu_and, c_alu_or, c_alu_add,
      c_alu_sub, c_alu_slt, c_alu_nor: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_alu.sv
`default_nettype none
// ============================================================================
// alu_share_ctrl_alu : combinational ALU (src1/src2/ctrl -> result/zero)
// Revision: 1.0
// ============================================================================
module alu_share_ctrl_alu
  import alu_share_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_src1,
  input  logic [DATA_W-1:0] i_src2,
  input  logic [3:0]        i_ctrl,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (i_ctrl)
      c_alu_and: w_result = i_src1 & i_src2;
      c_alu_or:  w_result = i_src1 | i_src2;
      c_alu_add: w_result = i_src1 + i_src2;
      c_alu_sub: w_result = i_src1 - i_src2;
      c_alu_slt: w_result = {{(DATA_W-1){1'b0}}, (i_src1 < i_src2)};
      c_alu_nor: w_result = ~(i_src1 | i_src2);
      default:   w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// alu_share_ctrl : arbitrates two requesters onto one ALU, registered response
// Revision: 1.0
// ============================================================================
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic [3:0]        req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  input  logic [3:0]        req1_ctrl_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_illegal_o
);

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_src1, r_src2;
  logic [3:0]        r_ctrl;
  logic [C_ID_W-1:0] r_id;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero, r_rsp_illegal;
  logic [C_ID_W-1:0] r_rsp_id;

  logic              w_accept_win, w_take, w_both_pick, w_grant_id, w_legal;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;

  // Under contention the round-robin picker favours whoever lost last time.
  if (RR_EN) begin : g_rr
    assign w_both_pick = ~r_last_grant;
  end else begin : g_fixed
    assign w_both_pick = 1'b0;
  end

  assign w_accept_win = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready_i);
  assign w_take       = w_accept_win && (req0_valid_i || req1_valid_i);
  assign w_grant_id   = (req0_valid_i && req1_valid_i) ? w_both_pick : req1_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_take) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready_i) w_state_nxt = w_take ? ST_EXEC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = w_take && !w_grant_id;
    req1_ready_o = w_take &&  w_grant_id;
    rsp_valid_o  = (r_state == ST_RESP);
  end

  alu_share_ctrl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_src1   (r_src1),
    .i_src2   (r_src2),
    .i_ctrl   (r_ctrl),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_legal = is_legal_ctrl(r_ctrl);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_src1        <= '0;
      r_src2        <= '0;
      r_ctrl        <= '0;
      r_id          <= '0;
      r_last_grant  <= 1'b1;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_id      <= '0;
    end else begin
      if (w_take) begin
        r_src1       <= w_grant_id ? req1_src1_i : req0_src1_i;
        r_src2       <= w_grant_id ? req1_src2_i : req0_src2_i;
        r_ctrl       <= w_grant_id ? req1_ctrl_i : req0_ctrl_i;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_result  <= w_legal ? w_alu_result : '0;
        r_rsp_zero    <= w_legal ? w_alu_zero : 1'b1;
        r_rsp_illegal <= !w_legal;
        r_rsp_id      <= r_id;
      end
    end
  end

  assign rsp_result_o  = r_rsp_result;
  assign rsp_zero_o    = r_rsp_zero;
  assign rsp_illegal_o = r_rsp_illegal;
  assign rsp_id_o      = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_share_ctrl : directed table, corner sequences and random vs model
// Revision: 1.0
// ============================================================================
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, rsp_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic        d_rdy0[2], d_rdy1[2], d_valid[2], d_id[2], d_zero[2], d_ill[2];
  logic [31:0] d_res[2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(32), .RR_EN(1'b1)) u_dut_rr (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(d_rdy0[0]), .req0_src1_i(a0), .req0_src2_i(b0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(d_rdy1[0]), .req1_src1_i(a1), .req1_src2_i(b1), .req1_ctrl_i(c1),
    .rsp_valid_o(d_valid[0]), .rsp_ready_i(rsp_ready), .rsp_id_o(d_id[0]),
    .rsp_result_o(d_res[0]), .rsp_zero_o(d_zero[0]), .rsp_illegal_o(d_ill[0]));

  alu_share_ctrl #(.DATA_W(32), .RR_EN(1'b0)) u_dut_fp (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(d_rdy0[1]), .req0_src1_i(a0), .req0_src2_i(b0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(d_rdy1[1]), .req1_src1_i(a1), .req1_src2_i(b1), .req1_ctrl_i(c1),
    .rsp_valid_o(d_valid[1]), .rsp_ready_i(rsp_ready), .rsp_id_o(d_id[1]),
    .rsp_result_o(d_res[1]), .rsp_zero_o(d_zero[1]), .rsp_illegal_o(d_ill[1]));

  typedef struct {
    bit          sel;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    bit          exp_zero;
    bit          exp_ill;
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          zero;
    bit          ill;
  } rsp_t;

  vec_t vecs[10];

  // transaction-level reference: one op in flight, one response slot
  bit   m_inflight[2], m_rv[2], m_last[2];
  rsp_t m_pend[2], m_rsp[2];
  logic [3:0] legal_codes[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rdy(input int k, input string tag, input bit r0, input bit r1);
    chk($sformatf("%s k%0d req0_ready", tag, k), 64'(d_rdy0[k]), 64'(r0));
    chk($sformatf("%s k%0d req1_ready", tag, k), 64'(d_rdy1[k]), 64'(r1));
  endtask

  task automatic chk_rsp(input int k, input string tag, input bit v, input bit id,
                         input logic [31:0] res, input bit z, input bit ill);
    chk($sformatf("%s k%0d rsp_valid", tag, k), 64'(d_valid[k]), 64'(v));
    if (v) begin
      chk($sformatf("%s k%0d rsp_id", tag, k), 64'(d_id[k]), 64'(id));
      chk($sformatf("%s k%0d rsp_result", tag, k), 64'(d_res[k]), 64'(res));
      chk($sformatf("%s k%0d rsp_zero", tag, k), 64'(d_zero[k]), 64'(z));
      chk($sformatf("%s k%0d rsp_illegal", tag, k), 64'(d_ill[k]), 64'(ill));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; c0 = 0; c1 = 0;
  endtask

  task automatic set_req(input bit sel, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin v1 = 1; c1 = c; a1 = a; b1 = b; end
    else     begin v0 = 1; c0 = c; a0 = a; b0 = b; end
  endtask

  function automatic rsp_t ref_op(input bit id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id = id; r.ill = 0;
    case (c)
      4'd0:    r.res = a & b;
      4'd1:    r.res = a | b;
      4'd2:    r.res = a + b;
      4'd6:    r.res = a - b;
      4'd7:    r.res = (a < b) ? 32'd1 : 32'd0;
      4'd12:   r.res = ~(a | b);
      default: begin r.res = 0; r.ill = 1; end
    endcase
    r.zero = (r.res == 0);
    return r;
  endfunction

  function automatic int m_winner(input int k);
    if (m_inflight[k] || (m_rv[k] && !rsp_ready)) return -1;
    if (v0 && v1) return (k == 0) ? (m_last[k] ? 0 : 1) : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0] = '{1'b0, 4'd2,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd6,  32'h5,         32'h5,          32'h0,         1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd7,  32'hFFFF_FFFF, 32'h1,          32'h0,         1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd7,  32'h1,         32'hFFFF_FFFF,  32'h1,         1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'd12, 32'h0,         32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd3,  32'h1234,      32'h5678,       32'h0,         1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'd1,  32'h0F0F_0000, 32'h0000_00F0,  32'h0F0F_00F0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'd6,  32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 4'd15, 32'hDEAD,      32'hBEEF,       32'h0,         1'b1, 1'b1};

    // ---------------- reset state ----------------
    rst_n = 0; rsp_ready = 0; idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset k%0d rsp_valid", k), 64'(d_valid[k]), 64'd0);
      chk($sformatf("reset k%0d rsp_result", k), 64'(d_res[k]), 64'd0);
      chk($sformatf("reset k%0d rsp_zero", k), 64'(d_zero[k]), 64'd0);
      chk($sformatf("reset k%0d rsp_illegal", k), 64'(d_ill[k]), 64'd0);
      chk($sformatf("reset k%0d rsp_id", k), 64'(d_id[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1;

    // ---------------- contention: RR alternates, fixed always req0 ----------------
    set_req(0, 4'd2, 32'd1, 32'd1);
    set_req(1, 4'd2, 32'd2, 32'd2);
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i > 0) begin
        chk_rsp(0, $sformatf("cont%0d", i), 1, 1'((i - 1) % 2), ((i - 1) % 2) ? 32'd4 : 32'd2, 0, 0);
        chk_rsp(1, $sformatf("cont%0d", i), 1, 0, 32'd2, 0, 0);
      end
      chk_rdy(0, $sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
      chk_rdy(1, $sformatf("cont%0d", i), 1, 0);
      tick();
      #1;
      for (int k = 0; k < 2; k++) begin
        chk_rdy(k, $sformatf("cont%0d exec", i), 0, 0);
        chk_rsp(k, $sformatf("cont%0d exec", i), 0, 0, 0, 0, 0);
      end
      tick();
    end
    idle_inputs();
    #1;
    chk_rsp(0, "cont_last", 1, 1, 32'd4, 0, 0);
    chk_rsp(1, "cont_last", 1, 0, 32'd2, 0, 0);
    tick();
    #1;
    chk_rsp(0, "cont_drain", 0, 0, 0, 0, 0);

    // ---------------- backpressure ----------------
    @(negedge clk);
    rsp_ready = 0;
    set_req(1, 4'd6, 32'd5, 32'd5);
    #1;
    chk_rdy(0, "bp grant", 0, 1);
    tick();
    idle_inputs();
    set_req(0, 4'd2, 32'd3, 32'd4);
    #1;
    chk_rdy(0, "bp exec", 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_rsp(0, $sformatf("bp hold%0d", i), 1, 1, 32'd0, 1, 0);
      chk_rdy(0, $sformatf("bp hold%0d", i), 0, 0);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk_rsp(0, "bp release", 1, 1, 32'd0, 1, 0);
    chk_rdy(0, "bp b2b", 1, 0);
    tick();
    idle_inputs();
    #1;
    chk_rsp(0, "bp b2b exec", 0, 0, 0, 0, 0);
    tick();
    #1;
    chk_rsp(0, "bp b2b rsp", 1, 0, 32'd7, 0, 0);
    tick();

    // ---------------- opcode table ----------------
    foreach (vecs[i]) begin
      idle_inputs();
      rsp_ready = 1;
      set_req(vecs[i].sel, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      #1;
      chk_rdy(0, $sformatf("vec%0d", i), !vecs[i].sel, vecs[i].sel);
      tick();
      idle_inputs();
      #1;
      chk_rsp(0, $sformatf("vec%0d exec", i), 0, 0, 0, 0, 0);
      tick();
      #1;
      for (int k = 0; k < 2; k++)
        chk_rsp(k, $sformatf("vec%0d", i), 1, vecs[i].sel, vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_ill);
      tick();
    end

    // ---------------- reset during EXEC, then during RESP ----------------
    set_req(1, 4'd0, 32'hFFFF, 32'h0F0F);
    tick();
    idle_inputs();
    rst_n = 0;
    #1;
    chk_rsp(0, "rst exec", 0, 0, 0, 0, 0);
    tick();
    #1;
    chk_rsp(0, "rst discard", 0, 0, 0, 0, 0);
    rst_n = 1;
    @(negedge clk);
    set_req(1, 4'd1, 32'h10, 32'h01);
    #1;
    chk_rdy(0, "post rst", 0, 1);
    tick();
    idle_inputs();
    tick();
    #1;
    chk_rsp(0, "post rst", 1, 1, 32'h11, 0, 0);
    tick();
    rsp_ready = 0;
    set_req(0, 4'd2, 32'd1, 32'd2);
    tick();
    idle_inputs();
    tick();
    #1;
    chk_rsp(0, "pre rst resp", 1, 0, 32'd3, 0, 0);
    rst_n = 0;
    #1;
    chk_rsp(0, "rst resp", 0, 0, 0, 0, 0);
    chk($sformatf("rst resp result"), 64'(d_res[0]), 64'd0);
    tick();
    rst_n = 1;

    // ---------------- random vs reference model ----------------
    for (int k = 0; k < 2; k++) begin
      m_inflight[k] = 0; m_rv[k] = 0; m_last[k] = 1;
    end
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      a0 = rnd_operand(); b0 = rnd_operand();
      a1 = rnd_operand(); b1 = rnd_operand();
      c0 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 5)];
      c1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 5)];
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      for (int k = 0; k < 2; k++) begin
        int w;
        w = m_winner(k);
        chk_rdy(k, $sformatf("rnd%0d", cyc), w == 0, w == 1);
        chk_rsp(k, $sformatf("rnd%0d", cyc), m_rv[k], m_rsp[k].id, m_rsp[k].res, m_rsp[k].zero, m_rsp[k].ill);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int w;
        w = m_winner(k);
        if (m_inflight[k]) begin
          m_rv[k] = 1;
          m_rsp[k] = m_pend[k];
          m_inflight[k] = 0;
        end else begin
          if (m_rv[k] && rsp_ready) m_rv[k] = 0;
          if (w >= 0) begin
            m_inflight[k] = 1;
            m_last[k] = 1'(w);
            m_pend[k] = (w == 1) ? ref_op(1, c1, a1, b1) : ref_op(0, c0, a0, b0);
          end
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
